// File: rtl/sj_zzdl_pkg.sv
// Shared types for the sj/zzdl arbiter: FSM states, requester index and the
// in-flight beat tag.
package sj_zzdl_pkg;

    // Owner indices are sized for the largest supported requester count (8).
    localparam int SJ_MAX_NREQ = 8;
    localparam int OWNER_W     = $clog2(SJ_MAX_NREQ);

    typedef logic [OWNER_W-1:0] owner_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } tag_t;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sj_zzdl_tag_pipe.sv
// Owner tags travelling alongside beats inside zzdl; flags any cycle where the
// delay line output and the tag stream disagree.
module sj_zzdl_tag_pipe
    import sj_zzdl_pkg::*;
#(
    parameter int DL_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    input  logic [OWNER_W-1:0] in_owner,
    input  logic               dl_out_vld,
    output logic               out_hit,
    output logic [OWNER_W-1:0] out_owner,
    output logic               any_vld,
    output logic               err
);

    tag_t stage_q [DL_LAT];
    tag_t stage_d [DL_LAT];
    logic err_q;
    logic err_d;

    always_comb begin
        stage_d[0] = '{vld: in_vld, owner: in_owner};
        for (int i = 1; i < DL_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DL_LAT; i++) begin
            any_vld = any_vld | stage_q[i].vld;
        end
    end

    // A beat with no tag, or a tag with no beat, latches err until reset.
    assign err_d     = err_q | (dl_out_vld != stage_q[DL_LAT-1].vld);
    assign out_hit   = dl_out_vld & stage_q[DL_LAT-1].vld;
    assign out_owner = stage_q[DL_LAT-1].owner;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DL_LAT; i++) begin
                stage_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < DL_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/sj_zzdl_arb.sv
// Round-robin burst arbiter sharing one zzdl delay line between NREQ sj
// requesters, routing each delayed beat back to the requester that issued it.
module sj_zzdl_arb
    import sj_zzdl_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int DW        = 32,
    parameter int DL_LAT    = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req_vld,
    input  logic [NREQ-1:0]    req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_rdy,
    output logic               dl_vld,
    output logic [DW-1:0]      dl_data,
    input  logic               dl_out_vld,
    input  logic [DW-1:0]      dl_out_data,
    output logic [NREQ-1:0]    rsp_vld,
    output logic [DW-1:0]      rsp_data,
    output logic               busy,
    output logic               err
);

    localparam int CW   = min1_clog2(MAX_BURST);
    localparam int SUMW = OWNER_W + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        rr_q, rr_d;
    owner_t        dl_owner_q, dl_owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dl_vld_q, dl_vld_d;
    logic [DW-1:0] dl_data_q, dl_data_d;

    logic [NREQ-1:0] rot;
    logic [NREQ-1:0] acc_vec;
    logic [SUMW-1:0] win_sum;
    owner_t          win_ofs;
    owner_t          win;
    logic            win_found;
    logic            accept;
    logic            acc_last;
    logic [DW-1:0]   sel_data;
    logic            tag_hit;
    owner_t          tag_owner;
    logic            tag_any;

    // Rotate requests so bit 0 is the round-robin pointer, then pick the first.
    always_comb begin
        rot       = NREQ'({req_vld, req_vld} >> rr_q);
        win_ofs   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found && rot[i]) begin
                win_found = 1'b1;
                win_ofs   = owner_t'(i);
            end
        end
        win_sum = {1'b0, rr_q} + {1'b0, win_ofs};
        win     = (win_sum >= SUMW'(NREQ)) ? owner_t'(win_sum - SUMW'(NREQ))
                                           : owner_t'(win_sum);
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign req_rdy[gi] = (state_q == ST_GRANT) && (owner_q == owner_t'(gi));
        assign rsp_vld[gi] = tag_hit && (tag_owner == owner_t'(gi));
    end

    assign acc_vec  = req_rdy & req_vld;
    assign accept   = |acc_vec;
    assign acc_last = |(acc_vec & req_last);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == owner_t'(i)) begin
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_en && win_found) begin
                    owner_d = win;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    if (acc_last || (cnt_q == CNT_LAST)) begin
                        rr_d    = (owner_q == owner_t'(NREQ - 1)) ? '0 : owner_q + owner_t'(1);
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dl_vld_d   = accept;
    assign dl_data_d  = accept ? sel_data : dl_data_q;
    assign dl_owner_d = accept ? owner_q : dl_owner_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_q       <= '0;
            cnt_q      <= '0;
            dl_vld_q   <= 1'b0;
            dl_data_q  <= '0;
            dl_owner_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            dl_vld_q   <= dl_vld_d;
            dl_data_q  <= dl_data_d;
            dl_owner_q <= dl_owner_d;
        end
    end

    // Stage 0 captures dl_vld on the same edge zzdl samples it.
    sj_zzdl_tag_pipe #(
        .DL_LAT (DL_LAT)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (dl_vld_q),
        .in_owner   (dl_owner_q),
        .dl_out_vld (dl_out_vld),
        .out_hit    (tag_hit),
        .out_owner  (tag_owner),
        .any_vld    (tag_any),
        .err        (err)
    );

    assign dl_vld   = dl_vld_q;
    assign dl_data  = dl_data_q;
    assign rsp_data = dl_out_data;
    assign busy     = (state_q == ST_GRANT) || tag_any;

endmodule

// File: tb/tb_sj_zzdl_arb.sv
// Randomised scoreboard bench for sj_zzdl_arb with a behavioural zzdl delay line.
module tb_sj_zzdl_arb;

    localparam int NREQ      = 2;
    localparam int DW        = 32;
    localparam int DL_LAT    = 4;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arb_en = 1'b0;
    logic [NREQ-1:0]    req_vld = '0;
    logic [NREQ-1:0]    req_last = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_rdy;
    logic               dl_vld;
    logic [DW-1:0]      dl_data;
    logic               dl_out_vld;
    logic [DW-1:0]      dl_out_data;
    logic [NREQ-1:0]    rsp_vld;
    logic [DW-1:0]      rsp_data;
    logic               busy;
    logic               err;
    logic               inj = 1'b0;

    sj_zzdl_arb #(
        .NREQ      (NREQ),
        .DW        (DW),
        .DL_LAT    (DL_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .req_vld     (req_vld),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_rdy     (req_rdy),
        .dl_vld      (dl_vld),
        .dl_data     (dl_data),
        .dl_out_vld  (dl_out_vld),
        .dl_out_data (dl_out_data),
        .rsp_vld     (rsp_vld),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Behavioural zzdl: fixed DL_LAT-cycle delay, sharing the arbiter reset.
    logic          zz_vld  [DL_LAT];
    logic [DW-1:0] zz_data [DL_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DL_LAT; i++) begin
                zz_vld[i]  <= 1'b0;
                zz_data[i] <= '0;
            end
        end else begin
            zz_vld[0]  <= dl_vld;
            zz_data[0] <= dl_data;
            for (int i = 1; i < DL_LAT; i++) begin
                zz_vld[i]  <= zz_vld[i-1];
                zz_data[i] <= zz_data[i-1];
            end
        end
    end
    assign dl_out_vld  = zz_vld[DL_LAT-1] | inj;
    assign dl_out_data = zz_data[DL_LAT-1];

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  exp_dl[$];
    exp_t  exp_rsp[$];
    int    grant_log[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   m_owner = -1;
    int   m_cnt = 0;
    int   m_rr = 0;
    int   acc_total = 0;
    int   gap_pct = 0;
    bit   rand_arb = 1'b0;
    logic exp_err = 1'b0;
    logic [NREQ-1:0] prev_rdy = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t qfront(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic push_burst(input int i, input int len, input logic [DW-1:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + DW'(k);
            b.last = (k == len - 1);
            if (i == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
    endtask

    task automatic drive();
        beat_t b;
        if (rand_arb) arb_en = ($urandom_range(99) < 80);
        for (int i = 0; i < NREQ; i++) begin
            if (qsize(i) > 0 && $urandom_range(99) >= gap_pct) begin
                b = qfront(i);
                req_vld[i]  = 1'b1;
                req_last[i] = b.last;
                req_data[i*DW +: DW] = b.data;
            end else begin
                req_vld[i]  = 1'b0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // Reference arbiter: who holds the grant, how many beats it has moved, and
    // who is next in round-robin order.
    task automatic model_cycle();
        logic [NREQ-1:0] exp_rdy;
        beat_t b;
        exp_t  e;
        exp_rdy = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        if (m_owner >= 0) begin
            chk("busy_in_grant", 64'(busy), 64'(1));
            if (req_vld[m_owner]) begin
                b = qfront(m_owner);
                qpop(m_owner);
                e.owner = m_owner;
                e.data  = b.data;
                e.cyc   = cyc + 1;
                exp_dl.push_back(e);
                e.cyc   = cyc + 1 + DL_LAT;
                exp_rsp.push_back(e);
                acc_total++;
                m_cnt++;
                if (b.last || m_cnt == MAX_BURST) begin
                    m_rr    = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end else if (arb_en && req_vld != '0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (m_owner < 0 && req_vld[(m_rr + k) % NREQ]) begin
                    m_owner = (m_rr + k) % NREQ;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    task automatic step(input bit chk_idle = 1'b0);
        @(negedge clk);
        if (chk_idle) chk("busy_idle", 64'(busy), 64'(0));
        if (!rst) model_cycle();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_arb = 1'b0;
        arb_en   = 1'b1;
        gap_pct  = 0;
        while ((qsize(0) + qsize(1) != 0 || m_owner >= 0 || exp_rsp.size() != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", 64'(n >= 300), 64'(0));
        step(1'b1);
    endtask

    task automatic chk_grants(input string name, input int exp_seq[$]);
        chk({name, "_count"}, 64'(grant_log.size()), 64'(exp_seq.size()));
        for (int k = 0; k < exp_seq.size() && k < grant_log.size(); k++) begin
            chk(name, 64'(grant_log[k]), 64'(exp_seq[k]));
        end
    endtask

    // Monitor: pops the scoreboards whenever the DUT presents a beat or response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rdy = '0;
                chk("reset_ctrl", 64'({req_rdy, dl_vld, rsp_vld, busy, err}), 64'(0));
                chk("reset_data", {dl_data, rsp_data}, 64'(0));
            end else begin
                if (req_rdy != '0 && prev_rdy == '0) grant_log.push_back(req_rdy[1] ? 1 : 0);
                prev_rdy = req_rdy;
                if (dl_vld) begin
                    if (exp_dl.size() == 0) begin
                        chk("dl_vld_unexpected", 64'(dl_vld), 64'(0));
                    end else begin
                        e = exp_dl.pop_front();
                        chk("dl_data", 64'(dl_data), 64'(e.data));
                        chk("dl_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (exp_dl.size() > 0 && exp_dl[0].cyc < cyc) begin
                    chk("dl_missing", 64'(cyc), 64'(exp_dl[0].cyc));
                    void'(exp_dl.pop_front());
                end
                if (rsp_vld != '0) begin
                    if (exp_rsp.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_vld), 64'(0));
                    end else begin
                        e = exp_rsp.pop_front();
                        chk("rsp_owner", 64'(rsp_vld), 64'(1) << e.owner);
                        chk("rsp_data", 64'(rsp_data), 64'(e.data));
                        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                        $display("rsp owner=%0d data=0x%08h cycle=%0d", e.owner, rsp_data, cyc);
                    end
                end
                if (exp_rsp.size() > 0 && exp_rsp[0].cyc < cyc) begin
                    chk("rsp_missing", 64'(cyc), 64'(exp_rsp[0].cyc));
                    void'(exp_rsp.pop_front());
                end
                chk("err", 64'(err), 64'(exp_err));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int start;
        int n;
        repeat (3) step();
        rst = 1'b0;
        arb_en = 1'b1;
        step();

        // Single 3-beat burst from requester 0.
        push_burst(0, 3, 32'hA0);
        drain();

        // Both requesters continuously valid with 2-beat bursts.
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            push_burst(0, 2, 32'h100 + 32'(k * 16));
            push_burst(1, 2, 32'h200 + 32'(k * 16));
        end
        drain();
        chk_grants("fair_grant", '{1, 0, 1, 0, 1, 0, 1, 0});

        // Long burst from requester 0 is split at MAX_BURST while 1 waits.
        grant_log.delete();
        push_burst(0, 10, 32'h300);
        step();
        step();
        push_burst(1, 2, 32'h400);
        drain();
        chk_grants("force_grant", '{0, 1, 0, 0});

        // Randomised traffic with gaps and arb_en toggling.
        gap_pct  = 30;
        rand_arb = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (qsize(i) < 4 && $urandom_range(3) == 0) push_burst(i, $urandom_range(1, 6), $urandom);
            end
            step();
        end
        drain();

        // Orphan beat out of zzdl: no response, err sticky from the next cycle.
        inj = 1'b1;
        @(negedge clk);
        chk("mismatch_rsp_vld", 64'(rsp_vld), 64'(0));
        model_cycle();
        @(posedge clk);
        #1;
        inj = 1'b0;
        exp_err = 1'b1;
        drive();
        repeat (3) step();

        // Reset in the middle of a burst.
        push_burst(0, 4, 32'h500);
        start = acc_total;
        n = 0;
        while (acc_total < start + 2 && n < 30) begin
            step();
            n++;
        end
        chk("reset_burst_timeout", 64'(n >= 30), 64'(0));
        rst = 1'b1;
        exp_err = 1'b0;
        q0.delete();
        q1.delete();
        exp_dl.delete();
        exp_rsp.delete();
        m_owner  = -1;
        m_cnt    = 0;
        m_rr     = 0;
        arb_en   = 1'b0;
        req_vld  = '0;
        req_last = '0;
        repeat (2) step();
        rst = 1'b0;
        repeat (DL_LAT + 4) step(1'b1);

        // arb_en low holds off grants; first grant after raising it goes to 0.
        grant_log.delete();
        push_burst(0, 2, 32'h600);
        push_burst(1, 2, 32'h700);
        repeat (3) step();
        chk("arb_en_hold_grants", 64'(grant_log.size()), 64'(0));
        drain();
        chk_grants("post_reset_grant", '{0, 1});
        chk("scoreboard_empty", 64'(exp_dl.size() + exp_rsp.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
